spi_apb_arbiter: RTL and testbench
==================================

Name: spi_apb_arbiter

Overview:
- Two-requester APB arbiter that shares one downstream APB slave: the SPI bridge serving XIP flash and the SPI master registers.
- Requester 0 is the instruction-fetch port; requester 1 is the load/store port.
- Uses round-robin grant, runs one outstanding transfer at a time, and holds the grant until the downstream completes.
- Decodes addresses and answers out-of-range requests locally with an error. An optional access timeout returns an error to the requester.

Parameters:
- FLASH_BASE, 32'h30000000, first flash (XIP) address
- FLASH_END, 32'h3fffffff, last flash address
- SPI_BASE, 32'h10001000, first SPI master register address
- SPI_END, 32'h10001fff, last SPI master register address
- TIMEOUT_CYCLES, 0, ACCESS-phase cycle limit; 0 disables the timeout

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- m0_psel / m1_psel  input  1  requester select
- m0_penable / m1_penable  input  1  requester access phase
- m0_paddr / m1_paddr  input  32  requester address
- m0_pwrite / m1_pwrite  input  1  requester write
- m0_pwdata / m1_pwdata  input  32  requester write data
- m0_pstrb / m1_pstrb  input  4  requester byte strobes
- m0_pprot / m1_pprot  input  3  requester protection
- m0_pready / m1_pready  output  1  response valid to requester
- m0_prdata / m1_prdata  output  32  read data to requester
- m0_pslverr / m1_pslverr  output  1  error to requester
- out_psel, out_penable, out_pwrite  output  1 each  downstream control
- out_paddr  output  32  downstream address
- out_pwdata  output  32  downstream write data
- out_pstrb  output  4  downstream byte strobes
- out_pprot  output  3  downstream protection
- out_pready  input  1  downstream ready
- out_prdata  input  32  downstream read data
- out_pslverr  input  1  downstream error

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - all outputs 0
  - state = IDLE
  - last_grant = 1, so requester 0 wins the first tie
  - timeout counter = 0
- A request is pending when mX_psel = 1. penable is not required for arbitration.
- Grant rules, evaluated only in IDLE:
  - one requester pending: grant it
  - both pending: grant the requester that is not last_grant
  - last_grant updates on every grant
- On grant, the winner's paddr, pwrite, pwdata, pstrb and pprot are latched. The latched values drive out_* for the whole transfer; later changes on the requester inputs are ignored.
- State machine:
  - IDLE → DECERR when the granted address is in neither [FLASH_BASE, FLASH_END] nor [SPI_BASE, SPI_END].
  - IDLE → SETUP otherwise.
  - SETUP: out_psel = 1, out_penable = 0, for one cycle → ACCESS.
  - ACCESS: out_psel = 1, out_penable = 1.
    - On out_pready = 1: latch out_prdata and out_pslverr → RESP.
    - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with out_pready still 0: latched prdata = 0, pslverr = 1 → RESP.
  - DECERR: latched prdata = 0, pslverr = 1 → RESP. Downstream is never touched.
  - RESP: for one cycle, the winner sees mX_pready = 1 with the latched prdata/pslverr; out_psel = out_penable = 0 → IDLE.
- Timeout counter: counts only in ACCESS and clears on entering SETUP.
- Latency, measured from the cycle psel is first sampled in IDLE:
  - downstream out_psel at +1
  - downstream access at +2
  - upstream pready at +3 minimum when out_pready = 1 in the first ACCESS cycle
  - decode error: pready at +2
- Upstream handshake rules:
  - mX_pready is asserted only in RESP, only for the granted requester, and only while that requester has psel = 1.
  - The loser's pready, prdata and pslverr stay 0.
  - The loser is held until the arbiter returns to IDLE.
- Requester drops psel before RESP (protocol violation): the downstream transfer still completes; the response is discarded and pready is not asserted.
- Back-to-back requests: a new grant is evaluated in the IDLE cycle after RESP, with no combinational pass-through.
- Reset mid-transfer: everything returns to reset values on the next edge. The downstream slave sees psel drop.
- On timeout the downstream slave sees psel drop mid-transfer; the slave must tolerate this.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum: IDLE, SETUP, ACCESS, DECERR, RESP
  - requester ID constants REQ_IFU = 0, REQ_LSU = 1
  - a struct bundling paddr/pwrite/pwdata/pstrb/pprot for the latched request
- No sub-module is required. The round-robin pick is a small function in the package.

Test Plan:
- Single read, m0 paddr = 32'h30000010, downstream ready in the first ACCESS cycle with prdata = 32'hDEADBEEF → m0_pready high exactly at cycle +3 with prdata = DEADBEEF and pslverr = 0; m1_pready stays 0 throughout.
- Simultaneous m0 and m1 reads held high for four consecutive transfers → grants are m0, m1, m0, m1; out_paddr always matches the granted requester.
- m1 write to paddr = 32'h20000000 → no out_psel ever; m1_pready at +2 with pslverr = 1 and prdata = 0.
- TIMEOUT_CYCLES = 8 with out_pready tied low → out_psel high for 9 cycles (1 SETUP + 8 ACCESS); m0_pslverr = 1; the arbiter accepts a new request afterwards.
- Downstream out_pslverr = 1 on an SPI register access at paddr = 32'h10001010 → the error propagates to the requester; latched prdata is passed through unchanged.
- Reset asserted during ACCESS → all outputs 0 on the next edge; after release, a tie goes to m0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI/APB arbiter: FSM states, requester IDs, latched request
// payload and the round-robin pick.
package spi_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned PROT_W = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR,
    RESP
  } state_e;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [PROT_W-1:0] pprot;
  } apb_req_t;

  // On a tie the requester that did not win last time goes next.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    if (req0 && req1) return ~last_grant;
    else if (req1)    return REQ_LSU;
    else              return REQ_IFU;
  endfunction

endpackage

// File: rtl/spi_apb_arbiter.sv
// Two-requester round-robin APB arbiter in front of one downstream slave, with local
// decode-error responses and an optional ACCESS-phase timeout.
module spi_apb_arbiter
  import spi_arb_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE     = 32'h3000_0000,
  parameter logic [31:0] FLASH_END      = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE       = 32'h1000_1000,
  parameter logic [31:0] SPI_END        = 32'h1000_1fff,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic              m0_pwrite,
  input  logic [DATA_W-1:0] m0_pwdata,
  input  logic [STRB_W-1:0] m0_pstrb,
  input  logic [PROT_W-1:0] m0_pprot,
  output logic              m0_pready,
  output logic [DATA_W-1:0] m0_prdata,
  output logic              m0_pslverr,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic              m1_pwrite,
  input  logic [DATA_W-1:0] m1_pwdata,
  input  logic [STRB_W-1:0] m1_pstrb,
  input  logic [PROT_W-1:0] m1_pprot,
  output logic              m1_pready,
  output logic [DATA_W-1:0] m1_prdata,
  output logic              m1_pslverr,
  output logic              out_psel,
  output logic              out_penable,
  output logic              out_pwrite,
  output logic [ADDR_W-1:0] out_paddr,
  output logic [DATA_W-1:0] out_pwdata,
  output logic [STRB_W-1:0] out_pstrb,
  output logic [PROT_W-1:0] out_pprot,
  input  logic              out_pready,
  input  logic [DATA_W-1:0] out_prdata,
  input  logic              out_pslverr
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  apb_req_t               req_q, req_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_psel_q, out_psel_d;
  logic                   out_penable_q, out_penable_d;
  logic [1:0]             pready_q, pready_d;
  logic [1:0][DATA_W-1:0] prdata_q, prdata_d;
  logic [1:0]             pslverr_q, pslverr_d;

  apb_req_t [1:0]         m_req;
  logic [1:0]             m_psel;
  logic                   win;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  // penable plays no part in arbitration
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign m_psel   = {m1_psel, m0_psel};
  assign m_req[0] = '{paddr: m0_paddr, pwrite: m0_pwrite, pwdata: m0_pwdata,
                      pstrb: m0_pstrb, pprot: m0_pprot};
  assign m_req[1] = '{paddr: m1_paddr, pwrite: m1_pwrite, pwdata: m1_pwdata,
                      pstrb: m1_pstrb, pprot: m1_pprot};

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    return ((a >= FLASH_BASE) && (a <= FLASH_END)) || ((a >= SPI_BASE) && (a <= SPI_END));
  endfunction

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    cnt_d        = cnt_q;
    win          = REQ_IFU;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    pready_d     = '0;
    prdata_d     = '0;
    pslverr_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (m0_psel || m1_psel) begin
          win          = rr_pick(m0_psel, m1_psel, last_grant_q);
          last_grant_d = win;
          req_d        = m_req[win];
          cnt_d        = '0;
          state_d      = addr_hit(m_req[win].paddr) ? SETUP : DECERR;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (out_pready) begin
          rsp_rdata = out_prdata;
          rsp_err   = out_pslverr;
          state_d   = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          rsp_err = 1'b1;
          state_d = RESP;
        end
      end
      DECERR: begin
        rsp_err = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    out_penable_d = (state_d == ACCESS);

    // A requester that dropped psel mid-transfer gets no response
    if ((state_d == RESP) && m_psel[last_grant_d]) begin
      pready_d[last_grant_d]  = 1'b1;
      prdata_d[last_grant_d]  = rsp_rdata;
      pslverr_d[last_grant_d] = rsp_err;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_LSU;
      req_q         <= '0;
      cnt_q         <= '0;
      out_psel_q    <= 1'b0;
      out_penable_q <= 1'b0;
      pready_q      <= '0;
      prdata_q      <= '0;
      pslverr_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      req_q         <= req_d;
      cnt_q         <= cnt_d;
      out_psel_q    <= out_psel_d;
      out_penable_q <= out_penable_d;
      pready_q      <= pready_d;
      prdata_q      <= prdata_d;
      pslverr_q     <= pslverr_d;
    end
  end

  assign out_psel    = out_psel_q;
  assign out_penable = out_penable_q;
  assign out_pwrite  = req_q.pwrite;
  assign out_paddr   = req_q.paddr;
  assign out_pwdata  = req_q.pwdata;
  assign out_pstrb   = req_q.pstrb;
  assign out_pprot   = req_q.pprot;
  assign m0_pready   = pready_q[0];
  assign m0_prdata   = prdata_q[0];
  assign m0_pslverr  = pslverr_q[0];
  assign m1_pready   = pready_q[1];
  assign m1_prdata   = prdata_q[1];
  assign m1_pslverr  = pslverr_q[1];

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Self-checking bench for spi_apb_arbiter: vector table, hand-written corner sequences
// and randomized transactions scored against a transaction-level reference model.
module tb_spi_apb_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
  logic [31:0] m0_paddr, m0_pwdata, m0_prdata;
  logic [3:0]  m0_pstrb;
  logic [2:0]  m0_pprot;
  logic        m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
  logic [31:0] m1_paddr, m1_pwdata, m1_prdata;
  logic [3:0]  m1_pstrb;
  logic [2:0]  m1_pprot;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic [3:0]  out_pstrb;
  logic [2:0]  out_pprot;

  spi_apb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
    .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pprot(m0_pprot),
    .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
    .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pprot(m1_pprot),
    .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
    .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pprot(out_pprot), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  int errors = 0;
  int checks = 0;
  int m_last = 1;

  typedef struct {
    logic s0, s1; logic [31:0] a0, a1; logic w0, w1;
    int wait_c; logic [31:0] sdata; logic serr;
    int exp_who; int exp_lat; logic [31:0] exp_rd; logic exp_err; int exp_pcyc;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic outs_zero();
    return ({m0_pready, m0_prdata, m0_pslverr, m1_pready, m1_prdata, m1_pslverr,
             out_psel, out_penable, out_pwrite, out_paddr, out_pwdata, out_pstrb,
             out_pprot} == '0);
  endfunction

  // Transaction-level expectation: who wins, when the response comes, what it carries.
  task automatic model(input logic s0, input logic s1, input logic [31:0] a0,
                       input logic [31:0] a1, input int wait_c, input logic [31:0] sdata,
                       input logic serr, output int who, output int lat,
                       output logic [31:0] rd, output logic er, output int pcyc,
                       output logic [31:0] addr);
    logic dec;
    if (s0 && s1) who = 1 - m_last;
    else          who = s0 ? 0 : 1;
    m_last = who;
    addr = (who == 1) ? a1 : a0;
    dec = (addr >= 32'h3000_0000 && addr <= 32'h3fff_ffff) ||
          (addr >= 32'h1000_1000 && addr <= 32'h1000_1fff);
    if (!dec)            begin lat = 2;          pcyc = 0;          rd = '0;    er = 1'b1; end
    else if (wait_c < 8) begin lat = 3 + wait_c; pcyc = 2 + wait_c; rd = sdata; er = serr; end
    else                 begin lat = 10;         pcyc = 9;          rd = '0;    er = 1'b1; end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    m0_psel = 1'b0; m1_psel = 1'b0; out_pready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset outputs zero", 32'(outs_zero()), 32'd1);
    reset = 1'b0;
    m_last = 1;
  endtask

  // Raise the requested psel lines, act as a slave with wait_c wait states, and
  // report what the upstream side observed.
  task automatic do_txn(input logic s0, input logic s1, input logic [31:0] a0,
                        input logic [31:0] a1, input logic w0, input logic w1,
                        input int wait_c, input logic [31:0] sdata, input logic serr,
                        output int who, output int lat, output logic [31:0] rd,
                        output logic er, output int pcyc, output logic [31:0] seen_addr,
                        output logic seen_wr, output logic loser_zero);
    int acc = 0;
    who = -1; lat = -1; rd = '0; er = 1'b0; pcyc = 0;
    seen_addr = '0; seen_wr = 1'b0; loser_zero = 1'b0;
    @(negedge clock);
    m0_psel = s0; m0_paddr = a0; m0_pwrite = w0; m0_pwdata = $urandom;
    m0_pstrb = 4'($urandom); m0_pprot = 3'($urandom); m0_penable = 1'b0;
    m1_psel = s1; m1_paddr = a1; m1_pwrite = w1; m1_pwdata = $urandom;
    m1_pstrb = 4'($urandom); m1_pprot = 3'($urandom); m1_penable = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
      if (out_psel) begin
        pcyc++;
        if (pcyc == 1) begin seen_addr = out_paddr; seen_wr = out_pwrite; end
      end
      if (out_psel && out_penable) begin
        if (acc == wait_c) begin out_pready = 1'b1; out_prdata = sdata; out_pslverr = serr; end
        acc++;
      end
      if (m0_pready || m1_pready) begin
        who = (m0_pready && m1_pready) ? 2 : (m1_pready ? 1 : 0);
        lat = c;
        rd  = m1_pready ? m1_prdata : m0_prdata;
        er  = m1_pready ? m1_pslverr : m0_pslverr;
        loser_zero = m1_pready ? (!m0_pready && m0_prdata == '0 && !m0_pslverr)
                               : (!m1_pready && m1_prdata == '0 && !m1_pslverr);
        break;
      end
    end
    m0_psel = 1'b0; m1_psel = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0:       return 32'h3000_0000 | ($urandom & 32'h0fff_ffff);
      1:       return 32'h1000_1000 | ($urandom & 32'h0000_0fff);
      2:       return $urandom;
      3:       return ($urandom % 2 == 0) ? 32'h2fff_ffff : 32'h4000_0000;
      default: return ($urandom % 2 == 0) ? 32'h1000_0fff : 32'h1000_2000;
    endcase
  endfunction

  initial begin
    int who, lat, pcyc, mwho, mlat, mpcyc, n, k;
    logic [31:0] rd, saddr, mrd, maddr, a0, a1, sd;
    logic er, swr, lz, merr, s0, s1, w0, w1, seen_bad;

    reset = 1'b1; out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
    m0_psel = 1'b0; m0_penable = 1'b0; m0_paddr = '0; m0_pwrite = 1'b0; m0_pwdata = '0;
    m0_pstrb = '0; m0_pprot = '0;
    m1_psel = 1'b0; m1_penable = 1'b0; m1_paddr = '0; m1_pwrite = 1'b0; m1_pwdata = '0;
    m1_pstrb = '0; m1_pprot = '0;

    vecs[0] = '{1, 0, 32'h3000_0010, 32'h0,         0, 0, 0,   32'hDEAD_BEEF, 0, 0, 3,  32'hDEAD_BEEF, 0, 2};
    vecs[1] = '{0, 1, 32'h0,         32'h2000_0000, 0, 1, 0,   32'h5555_5555, 0, 1, 2,  32'h0,         1, 0};
    vecs[2] = '{1, 0, 32'h1000_1010, 32'h0,         0, 0, 2,   32'h1234_5678, 1, 0, 5,  32'h1234_5678, 1, 4};
    vecs[3] = '{1, 1, 32'h3000_0100, 32'h1000_1ffc, 0, 1, 1,   32'hA5A5_A5A5, 0, 1, 4,  32'hA5A5_A5A5, 0, 3};
    vecs[4] = '{1, 1, 32'h3fff_ffff, 32'h3000_0000, 0, 0, 0,   32'h0BAD_F00D, 0, 0, 3,  32'h0BAD_F00D, 0, 2};
    vecs[5] = '{0, 1, 32'h0,         32'h1000_0fff, 0, 0, 0,   32'h7777_7777, 0, 1, 2,  32'h0,         1, 0};
    vecs[6] = '{1, 0, 32'h4000_0000, 32'h0,         1, 0, 0,   32'h7777_7777, 0, 0, 2,  32'h0,         1, 0};
    vecs[7] = '{1, 0, 32'h1000_1000, 32'h0,         0, 0, 100, 32'h1111_1111, 0, 0, 10, 32'h0,         1, 9};
    vecs[8] = '{0, 1, 32'h0,         32'h1000_1fff, 0, 0, 3,   32'hCAFE_F00D, 0, 1, 6,  32'hCAFE_F00D, 0, 5};
    vecs[9] = '{1, 1, 32'h2fff_ffff, 32'h3000_0000, 0, 0, 0,   32'h9999_9999, 0, 0, 2,  32'h0,         1, 0};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].s0, vecs[i].s1, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1,
             vecs[i].wait_c, vecs[i].sdata, vecs[i].serr, who, lat, rd, er, pcyc, saddr, swr, lz);
      model(vecs[i].s0, vecs[i].s1, vecs[i].a0, vecs[i].a1, vecs[i].wait_c, vecs[i].sdata,
            vecs[i].serr, mwho, mlat, mrd, merr, mpcyc, maddr);
      check($sformatf("vec%0d winner", i), 32'(who), 32'(vecs[i].exp_who));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d pslverr", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d psel cycles", i), 32'(pcyc), 32'(vecs[i].exp_pcyc));
      check($sformatf("vec%0d loser quiet", i), 32'(lz), 32'd1);
      if (pcyc > 0) check($sformatf("vec%0d out_paddr", i), saddr, maddr);
    end

    // Both requesters held high through four transfers: strict alternation from m0.
    do_reset();
    @(negedge clock);
    a0 = 32'h3000_0200; a1 = 32'h1000_1100;
    m0_psel = 1'b1; m0_paddr = a0; m0_pwrite = 1'b0;
    m1_psel = 1'b1; m1_paddr = a1; m1_pwrite = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clock);
      out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
      if (out_psel && !out_penable) check("b2b setup addr", out_paddr, (n % 2 == 1) ? a1 : a0);
      if (out_psel && out_penable) begin out_pready = 1'b1; out_prdata = out_paddr; end
      if (m0_pready || m1_pready) begin
        check("b2b winner", 32'(m1_pready), 32'(n % 2));
        check("b2b prdata", m1_pready ? m1_prdata : m0_prdata, (n % 2 == 1) ? a1 : a0);
        n++;
      end
    end
    check("b2b transfers", 32'(n), 32'd4);
    m0_psel = 1'b0; m1_psel = 1'b0;
    m_last = 1;

    // m0 abandons the transfer during ACCESS: downstream completes, no response upstream.
    @(negedge clock);
    m0_psel = 1'b1; m0_paddr = 32'h3000_0004;
    k = 0;
    while (!out_penable && k < 10) begin @(negedge clock); k++; end
    check("drop reached access", 32'(out_penable), 32'd1);
    m0_psel = 1'b0; out_pready = 1'b1; out_prdata = 32'h1357_9bdf;
    seen_bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      out_pready = 1'b0;
      if (m0_pready || m1_pready) seen_bad = 1'b1;
    end
    check("drop no pready", 32'(seen_bad), 32'd0);
    check("drop downstream released", 32'(out_psel), 32'd0);
    m_last = 0;

    // Reset during ACCESS clears everything; the next tie goes to m0.
    @(negedge clock);
    m0_psel = 1'b1; m0_paddr = 32'h3000_0008;
    k = 0;
    while (!out_penable && k < 10) begin @(negedge clock); k++; end
    check("rst reached access", 32'(out_penable), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst mid-access outputs zero", 32'(outs_zero()), 32'd1);
    reset = 1'b0; m0_psel = 1'b0;
    m_last = 1;
    do_txn(1, 1, 32'h3000_0040, 32'h3000_0080, 0, 0, 0, 32'h2468_ace0, 0,
           who, lat, rd, er, pcyc, saddr, swr, lz);
    model(1, 1, 32'h3000_0040, 32'h3000_0080, 0, 32'h2468_ace0, 0,
          mwho, mlat, mrd, merr, mpcyc, maddr);
    check("post-reset tie winner", 32'(who), 32'd0);
    check("post-reset tie prdata", rd, 32'h2468_ace0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 30; i++) begin
      s0 = 1'($urandom); s1 = 1'($urandom);
      if (!s0 && !s1) s0 = 1'b1;
      a0 = rand_addr(); a1 = rand_addr();
      w0 = 1'($urandom); w1 = 1'($urandom);
      k  = ($urandom_range(0, 5) == 0) ? 12 : $urandom_range(0, 3);
      sd = $urandom;
      merr = 1'($urandom);
      do_txn(s0, s1, a0, a1, w0, w1, k, sd, merr, who, lat, rd, er, pcyc, saddr, swr, lz);
      model(s0, s1, a0, a1, k, sd, merr, mwho, mlat, mrd, merr, mpcyc, maddr);
      check($sformatf("rnd%0d winner", i), 32'(who), 32'(mwho));
      check($sformatf("rnd%0d latency", i), 32'(lat), 32'(mlat));
      check($sformatf("rnd%0d prdata", i), rd, mrd);
      check($sformatf("rnd%0d pslverr", i), 32'(er), 32'(merr));
      check($sformatf("rnd%0d psel cycles", i), 32'(pcyc), 32'(mpcyc));
      check($sformatf("rnd%0d loser quiet", i), 32'(lz), 32'd1);
      if (mpcyc > 0) begin
        check($sformatf("rnd%0d out_paddr", i), saddr, maddr);
        check($sformatf("rnd%0d out_pwrite", i), 32'(swr), 32'((mwho == 1) ? w1 : w0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
